// File: rtl/btn_debounce.sv
// Debounces N raw push-button/switch inputs into clean clock-synchronous levels,
// with one-cycle edge pulses and a sticky press flag for polling consumers.
module btn_debounce #(
    parameter int BTN_COUNT       = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int COUNTER_WIDTH   = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BTN_COUNT-1:0] btn_raw,
    output logic [BTN_COUNT-1:0] btn_level,
    output logic [BTN_COUNT-1:0] btn_rise,
    output logic [BTN_COUNT-1:0] btn_fall,
    output logic                 btn_changed,
    output logic [BTN_COUNT-1:0] press_pending,
    input  logic [BTN_COUNT-1:0] press_ack
);

    localparam longint MAX_CYCLES = (longint'(1) << COUNTER_WIDTH) - 1;

    generate
        if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > MAX_CYCLES) begin : g_bad_cycles
            $error("btn_debounce: DEBOUNCE_CYCLES out of range for COUNTER_WIDTH");
        end
    endgenerate

    localparam logic [COUNTER_WIDTH-1:0] TERMINAL = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [BTN_COUNT-1:0]     sync1;
    logic [BTN_COUNT-1:0]     sync2;
    logic [COUNTER_WIDTH-1:0] cnt     [BTN_COUNT];
    logic [COUNTER_WIDTH-1:0] cnt_nxt [BTN_COUNT];
    logic [BTN_COUNT-1:0]     level_nxt;
    logic [BTN_COUNT-1:0]     rise_nxt;
    logic [BTN_COUNT-1:0]     fall_nxt;

    // A channel flips only after DEBOUNCE_CYCLES consecutive mismatching samples;
    // any agreement in between drops the partial count.
    always_comb begin
        level_nxt = btn_level;
        rise_nxt  = '0;
        fall_nxt  = '0;
        for (int i = 0; i < BTN_COUNT; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != btn_level[i]) begin
                if (cnt[i] == TERMINAL) begin
                    level_nxt[i] = sync2[i];
                    rise_nxt[i]  = sync2[i];
                    fall_nxt[i]  = ~sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + COUNTER_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1         <= '0;
            sync2         <= '0;
            btn_level     <= '0;
            btn_rise      <= '0;
            btn_fall      <= '0;
            btn_changed   <= 1'b0;
            press_pending <= '0;
            for (int i = 0; i < BTN_COUNT; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1       <= btn_raw;
            sync2       <= sync1;
            btn_level   <= level_nxt;
            btn_rise    <= rise_nxt;
            btn_fall    <= fall_nxt;
            btn_changed <= |(rise_nxt | fall_nxt);
            // A rise arriving together with an ack keeps the flag set.
            press_pending <= (press_pending & ~press_ack) | btn_rise;
            for (int i = 0; i < BTN_COUNT; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Input-side counterpart to the board LED driver: conditions N raw push-button/switch inputs into clean, clock-synchronous levels.
- Per channel: a 2-FF synchronizer, a stability counter, a debounced level, and one-cycle rise/fall pulses.
- A sticky press flag with an acknowledge handshake lets a polling consumer (CPU-side GPIO/status logic) catch presses it would otherwise miss.

Parameters:
- BTN_COUNT, 16, number of independent input channels.
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronized input must differ from the debounced state before the state flips. Legal range 1 .. 2^COUNTER_WIDTH-1; any other value is an elaboration error.
- COUNTER_WIDTH, 20, width of each per-channel stability counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  BTN_COUNT  asynchronous raw button/switch inputs.
- btn_level  output  BTN_COUNT  debounced level per channel.
- btn_rise  output  BTN_COUNT  one-cycle pulse when btn_level goes 0->1.
- btn_fall  output  BTN_COUNT  one-cycle pulse when btn_level goes 1->0.
- btn_changed  output  1  OR-reduction of btn_rise | btn_fall, registered (same cycle as the pulses).
- press_pending  output  BTN_COUNT  sticky per-channel flag, set by rise.
- press_ack  input  BTN_COUNT  per-channel clear for press_pending.

Behaviour:
- Reset
  - Applies when rst=1 at a rising edge.
  - Clears both synchronizer stages, all counters, btn_level, btn_rise, btn_fall, btn_changed and press_pending to 0.
  - Reset asserted mid-count discards the partial count.
- Synchronizer: sync1 <= btn_raw; sync2 <= sync1. Only sync2 feeds the debounce logic.
- Per channel i, each edge (not in reset):
  - sync2[i] == btn_level[i]: cnt <= 0; no pulse.
  - sync2[i] != btn_level[i] and cnt == DEBOUNCE_CYCLES-1: btn_level <= sync2; cnt <= 0; assert rise or fall for this cycle.
  - Otherwise: cnt <= cnt+1.
- Latency: a raw change set up before edge E0 and held stable appears on btn_level (and its pulse) after edge E(DEBOUNCE_CYCLES+1), i.e. DEBOUNCE_CYCLES+2 edges total. With DEBOUNCE_CYCLES=1 this is 3 edges.
- Glitch rejection: a mismatch lasting fewer than DEBOUNCE_CYCLES sync2 cycles returns cnt to 0 and produces no level change. A bounce in either direction restarts the count.
- Pulses: btn_rise and btn_fall are registered and high for exactly one cycle. They are never both high on the same channel. Channels are fully independent; simultaneous events on several channels each pulse.
- btn_changed: registered OR of the next-state rise|fall vector, so it aligns with the pulses.
- press_pending[i]
  - Set the cycle after btn_rise[i] is high.
  - Cleared by press_ack[i]=1 at an edge.
  - Rise and ack on the same channel in the same cycle: set wins, flag stays 1.
  - Ack with flag already 0: no effect.
- Counter never wraps: the DEBOUNCE_CYCLES-1 compare resets it first.
- Reset released while btn_raw is held high is treated as a press: rise pulse after DEBOUNCE_CYCLES+2 edges.

Test Plan (DEBOUNCE_CYCLES=4, BTN_COUNT=4, COUNTER_WIDTH=4):
- Clean press: rst then btn_raw=0001 held from edge 0. Required: btn_level[0]=1 and btn_rise=0001 for one cycle after edge 5; btn_changed=1 the same cycle; press_pending=0001 from the following cycle.
- Bounce rejection: btn_raw[1] toggles 1,0,1,0 with each value held 3 cycles, then held 1. Required: no pulse during bouncing; single btn_rise[1] 6 edges after the final stable transition.
- Release: from btn_level=0001, drive btn_raw=0000. Required: btn_fall=0001 for one cycle after edge 5; press_pending unchanged.
- Ack race: btn_rise[2] pulses in the cycle press_ack[2]=1. Required: press_pending[2] stays 1. A later ack alone clears it to 0.
- Mid-count reset: btn_raw=1000, assert rst at edge 3 for one cycle. Required: all outputs 0. btn_rise[3] occurs 6 edges after rst deasserts, not before.
- Simultaneous: btn_raw 0000->1111 at once. Required: btn_rise=1111 in a single cycle; btn_changed high exactly one cycle.
